// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx byte transmitter between NUM_REQ byte-stream requesters, round-robin per message.
// Latency: grant one cycle after req_valid in IDLE; per byte 3 overhead cycles plus the uart frame time.
// Backpressure: req_ready only in ISSUE for the owner; one byte in flight, next accepted after tx_busy falls.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 16,
    parameter int GAP_CYCLES = 1250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_data_valid,
    input  logic                   i_tx_busy,
    output logic [2:0]             o_grant_id,
    output logic                   o_grant_active
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam int              GW         = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [8:0]      BURST_LAST = 9'(MAX_BURST);

    logic [2:0]    r_state;
    logic [2:0]    r_rr_ptr;
    logic [2:0]    r_grant_id;
    logic          r_grant_active;
    logic [7:0]    r_byte_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_last_flag;
    logic [7:0]    r_tx_data;

    logic          w_any;
    logic          w_hi_found;
    logic [2:0]    w_pick_lo;
    logic [2:0]    w_pick_hi;
    logic [2:0]    w_pick;
    logic          w_sel_valid;
    logic          w_sel_last;
    logic [7:0]    w_sel_data;
    logic          w_burst_end;

    // Round-robin pick: lowest requester above rr_ptr, otherwise wrap to the lowest requester overall.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_pick_lo  = '0;
        w_pick_hi  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                w_any     = 1'b1;
                w_pick_lo = 3'(i);
                if (i > int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_pick_hi  = 3'(i);
                end
            end
        end
        w_pick = w_hi_found ? w_pick_hi : w_pick_lo;
    end

    // Select the owner's byte stream and drive its ready while the FSM is waiting for a byte.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == 3'(i)) begin
                w_sel_valid    = i_req_valid[i];
                w_sel_last     = i_req_last[i];
                w_sel_data     = i_req_data[i*8 +: 8];
                o_req_ready[i] = (r_state == S_ISSUE);
            end
        end
    end

    // The byte being accepted now is the last one this grant may send.
    assign w_burst_end = (({1'b0, r_byte_cnt} + 9'd1) == BURST_LAST);

    // Grant/issue FSM: one byte in flight, grant kept until last byte, burst cap or idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= 3'(NUM_REQ - 1);
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_byte_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_last_flag    <= 1'b0;
            r_tx_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant_id     <= w_pick;
                        r_grant_active <= 1'b1;
                        r_byte_cnt     <= '0;
                        r_gap_cnt      <= '0;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_sel_valid) begin
                        r_tx_data   <= w_sel_data;
                        r_last_flag <= w_sel_last | w_burst_end;
                        r_byte_cnt  <= r_byte_cnt + 8'd1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_START;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        // Owner went quiet mid-message: hand the transmitter on.
                        r_rr_ptr       <= r_grant_id;
                        r_grant_active <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (r_last_flag) begin
                            r_rr_ptr       <= r_grant_id;
                            r_grant_active <= 1'b0;
                            r_state        <= S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data       = r_tx_data;
    assign o_tx_data_valid = (r_state == S_START);
    assign o_grant_id      = r_grant_id;
    assign o_grant_active  = r_grant_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level queue model of round-robin service plus a uart busy model.
// Directed per-requester message queues; one compare process checks every cycle against the model.
// Literal expectations pin grant order, byte values, per-byte spacing and the idle-gap length.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int MAX_BURST  = 4;
    localparam int GAP_CYCLES = 20;
    localparam int BUSY_CYC   = 30;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   i_req_last;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [7:0]           o_tx_data;
    logic                 o_tx_data_valid;
    logic                 i_tx_busy;
    logic [2:0]           o_grant_id;
    logic                 o_grant_active;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MAX_BURST  (MAX_BURST),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req_valid     (i_req_valid),
        .i_req_data      (i_req_data),
        .i_req_last      (i_req_last),
        .o_req_ready     (o_req_ready),
        .o_tx_data       (o_tx_data),
        .o_tx_data_valid (o_tx_data_valid),
        .i_tx_busy       (i_tx_busy),
        .o_grant_id      (o_grant_id),
        .o_grant_active  (o_grant_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gap_seen = 0;

    logic        drv_en   = 1'b0;
    logic        stim_all = 1'b0;
    logic [8:0]  txq   [NUM_REQ][$];
    logic [10:0] exp_b [$];
    int          exp_g [$];
    int          grant_log [$];
    int          pulse_cyc [$];
    int          pulse_dat [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_msg(input int r, input int n, input int base, input bit last);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'(base + k);
            txq[r].push_back({(last && (k == n - 1)), b});
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (txq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Service order from the queues: round robin after reset, each grant runs to its
    // last byte, MAX_BURST bytes, or until the requester runs dry (idle-gap release).
    function automatic void model_plan();
        logic [8:0] c [NUM_REQ][$];
        logic [8:0] e;
        int rr, id, n, j;
        bit done;
        for (int i = 0; i < NUM_REQ; i++) c[i] = txq[i];
        rr = NUM_REQ - 1;
        forever begin
            id = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (rr + k) % NUM_REQ;
                if (id < 0 && c[j].size() > 0) id = j;
            end
            if (id < 0) break;
            exp_g.push_back(id);
            n = 0;
            done = 1'b0;
            while (!done) begin
                e = c[id].pop_front();
                exp_b.push_back({id[2:0], e[7:0]});
                n++;
                done = e[8] || (n == MAX_BURST) || (c[id].size() == 0);
            end
            rr = id;
        end
    endfunction

    // Requester drivers: decide acceptance mid-cycle, update presented bytes just after the edge.
    initial begin
        logic [NUM_REQ-1:0] take;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        forever begin
            @(negedge clk);
            take = rst_n ? (o_req_ready & i_req_valid) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (take[i] && txq[i].size() > 0) void'(txq[i].pop_front());
                if (stim_all) begin
                    i_req_valid[i]       = 1'b1;
                    i_req_data[i*8 +: 8] = 8'hFF;
                    i_req_last[i]        = 1'b0;
                end else if (drv_en && txq[i].size() > 0) begin
                    i_req_valid[i]       = 1'b1;
                    i_req_data[i*8 +: 8] = txq[i][0][7:0];
                    i_req_last[i]        = txq[i][0][8];
                end else begin
                    i_req_valid[i]       = 1'b0;
                    i_req_data[i*8 +: 8] = 8'h00;
                    i_req_last[i]        = 1'b0;
                end
            end
        end
    end

    // uart_tx stand-in: busy from the cycle after the pulse for BUSY_CYC cycles, ignores reset.
    initial begin
        i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_data_valid) begin
                @(posedge clk);
                #1 i_tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge clk);
                #1 i_tx_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model and the output rules.
    initial begin
        bit         prev_active = 1'b0;
        logic [2:0] prev_id     = '0;
        logic [7:0] last_dat    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_eq("reset_outputs", {o_req_ready, o_tx_data, o_tx_data_valid, o_grant_active}, 0);
                prev_active = 1'b0;
            end else begin
                if (o_req_ready != '0)
                    check_eq("ready_owner", o_req_ready, o_grant_active ? (1 << o_grant_id) : 0);
                if (prev_active && o_grant_active)
                    check_eq("grant_stable", o_grant_id, prev_id);
                if (o_grant_active && !prev_active) begin
                    grant_log.push_back(o_grant_id);
                    if (exp_g.size() == 0) check_eq("grant_unexpected", o_grant_id, -1);
                    else check_eq("grant_order", o_grant_id, exp_g.pop_front());
                end
                if (o_tx_data_valid) begin
                    pulse_cyc.push_back(cyc);
                    pulse_dat.push_back(o_tx_data);
                    check_eq("pulse_uart_idle", i_tx_busy, 0);
                    check_eq("pulse_granted", o_grant_active, 1);
                    if (exp_b.size() == 0) check_eq("byte_unexpected", {o_grant_id, o_tx_data}, -1);
                    else check_eq("tx_byte", {o_grant_id, o_tx_data}, exp_b.pop_front());
                    last_dat = o_tx_data;
                end
                if (i_tx_busy && o_grant_active)
                    check_eq("tx_data_hold", o_tx_data, last_dat);
                if ((o_req_ready & ~i_req_valid) != '0) gap_seen++;
                prev_active = o_grant_active;
                prev_id     = o_grant_id;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        drv_en = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) txq[i].delete();
        exp_b.delete();
        exp_g.delete();
        for (int k = 0; k < 200 && i_tx_busy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (all_empty() && !o_grant_active && !i_tx_busy) break;
        end
        check_eq({nm, "_finished"}, int'(k < 3000), 1);
        check_eq({nm, "_model_left"}, exp_b.size() + exp_g.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, g0, gb, k;
        rst_n = 1'b0;

        // 1: reset holds outputs low even with every requester valid
        stim_all = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t1_ready",  o_req_ready, 0);
        check_eq("t1_pulse",  o_tx_data_valid, 0);
        check_eq("t1_grant",  o_grant_active, 0);
        stim_all = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t1_idle_grant", o_grant_active, 0);
        check_eq("t1_idle_ready", o_req_ready, 0);
        check_eq("t1_no_grants",  grant_log.size(), 0);

        // 2: single three-byte message from requester 0
        apply_reset();
        push_msg(0, 3, 8'h41, 1'b1);
        model_plan();
        p0 = pulse_cyc.size();
        g0 = grant_log.size();
        drv_en = 1'b1;
        wait_idle("t2");
        check_eq("t2_pulses", pulse_cyc.size() - p0, 3);
        check_eq("t2_grants", grant_log.size() - g0, 1);
        if (pulse_cyc.size() - p0 == 3) begin
            check_eq("t2_byte0", pulse_dat[p0],     8'h41);
            check_eq("t2_byte1", pulse_dat[p0 + 1], 8'h42);
            check_eq("t2_byte2", pulse_dat[p0 + 2], 8'h43);
            check_eq("t2_spacing01", pulse_cyc[p0 + 1] - pulse_cyc[p0],     BUSY_CYC + 3);
            check_eq("t2_spacing12", pulse_cyc[p0 + 2] - pulse_cyc[p0 + 1], BUSY_CYC + 3);
        end
        if (grant_log.size() > g0) check_eq("t2_owner", grant_log[g0], 0);

        // 3: all three valid with 2-byte messages, requester 0 has a second message
        apply_reset();
        push_msg(0, 2, 8'h10, 1'b1);
        push_msg(0, 2, 8'h14, 1'b1);
        push_msg(1, 2, 8'h20, 1'b1);
        push_msg(2, 2, 8'h30, 1'b1);
        model_plan();
        p0 = pulse_cyc.size();
        g0 = grant_log.size();
        gb = gap_seen;
        drv_en = 1'b1;
        wait_idle("t3");
        check_eq("t3_pulses", pulse_cyc.size() - p0, 8);
        check_eq("t3_no_gap", gap_seen - gb, 0);
        if (grant_log.size() - g0 == 4) begin
            check_eq("t3_grant0", grant_log[g0],     0);
            check_eq("t3_grant1", grant_log[g0 + 1], 1);
            check_eq("t3_grant2", grant_log[g0 + 2], 2);
            check_eq("t3_grant3", grant_log[g0 + 3], 0);
        end else check_eq("t3_grants", grant_log.size() - g0, 4);

        // 4: burst cap splits requester 1's 6-byte stream around requester 2's message
        apply_reset();
        push_msg(1, 6, 8'h50, 1'b0);
        push_msg(2, 2, 8'h60, 1'b1);
        model_plan();
        p0 = pulse_cyc.size();
        g0 = grant_log.size();
        drv_en = 1'b1;
        wait_idle("t4");
        check_eq("t4_pulses", pulse_cyc.size() - p0, 8);
        if (grant_log.size() - g0 == 3) begin
            check_eq("t4_grant0", grant_log[g0],     1);
            check_eq("t4_grant1", grant_log[g0 + 1], 2);
            check_eq("t4_grant2", grant_log[g0 + 2], 1);
        end else check_eq("t4_grants", grant_log.size() - g0, 3);
        if (pulse_cyc.size() - p0 == 8) begin
            check_eq("t4_fourth", pulse_dat[p0 + 3], 8'h53);
            check_eq("t4_fifth",  pulse_dat[p0 + 4], 8'h60);
        end

        // 5: requester 0 goes quiet mid-message, requester 2 served after the gap
        apply_reset();
        push_msg(0, 1, 8'h70, 1'b0);
        push_msg(2, 1, 8'h72, 1'b1);
        model_plan();
        g0 = grant_log.size();
        gb = gap_seen;
        drv_en = 1'b1;
        wait_idle("t5");
        check_eq("t5_gap_cycles", gap_seen - gb, GAP_CYCLES);
        if (grant_log.size() - g0 == 2) begin
            check_eq("t5_grant0", grant_log[g0],     0);
            check_eq("t5_grant1", grant_log[g0 + 1], 2);
        end else check_eq("t5_grants", grant_log.size() - g0, 2);

        // 6: reset while the first byte is on the wire, remaining bytes resume afterwards
        apply_reset();
        push_msg(0, 3, 8'h61, 1'b1);
        model_plan();
        p0 = pulse_cyc.size();
        drv_en = 1'b1;
        for (k = 0; k < 500 && pulse_cyc.size() == p0; k++) @(negedge clk);
        check_eq("t6_first_pulse", int'(pulse_cyc.size() > p0), 1);
        repeat (5) @(negedge clk);
        check_eq("t6_pre_grant", o_grant_active, 1);
        #2;
        rst_n  = 1'b0;
        drv_en = 1'b0;
        #1;
        check_eq("t6_async_grant", o_grant_active, 0);
        check_eq("t6_async_ready", o_req_ready, 0);
        check_eq("t6_async_pulse", o_tx_data_valid, 0);
        check_eq("t6_async_data",  o_tx_data, 0);
        exp_b.delete();
        exp_g.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_plan();
        for (k = 0; k < 500 && i_tx_busy; k++) @(negedge clk);
        p0 = pulse_cyc.size();
        g0 = grant_log.size();
        drv_en = 1'b1;
        wait_idle("t6");
        check_eq("t6_resumed_pulses", pulse_cyc.size() - p0, 2);
        if (pulse_cyc.size() - p0 == 2) begin
            check_eq("t6_byte1", pulse_dat[p0],     8'h62);
            check_eq("t6_byte2", pulse_dat[p0 + 1], 8'h63);
        end
        if (grant_log.size() > g0) check_eq("t6_owner", grant_log[g0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
